// File: rtl/ebr_port_arbiter_if.sv
// Bundle for the two requester ports, the shared response and the EBR mode-0 pins.
// slave: arbiter view. master: clients plus the RAM primitive's registered output.
interface ebr_port_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    // Requester A
    logic              a_valid;
    logic              a_ready;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_mask;
    logic              a_rsp_valid;

    // Requester B
    logic              b_valid;
    logic              b_ready;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_mask;
    logic              b_rsp_valid;

    // Shared read data, qualified by a_rsp_valid / b_rsp_valid
    logic [DATA_W-1:0] rsp_rdata;

    // EBR pins
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_mask;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata, a_mask,
        input  b_valid, b_we, b_addr, b_wdata, b_mask,
        output a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_rdata,
        output ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata, ram_mask,
        input  ram_rdata
    );

    modport master (
        output a_valid, a_we, a_addr, a_wdata, a_mask,
        output b_valid, b_we, b_addr, b_wdata, b_mask,
        input  a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_rdata,
        input  ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata, ram_mask,
        output ram_rdata
    );
endinterface

// File: rtl/ebr_port_arbiter.sv
// Two-requester arbiter for one iCE40 EBR in mode 0 (256 x 16, one read + one write port).
// Reads and writes are arbitrated independently with separate round-robin pointers, so one
// read and one write can issue in the same cycle. A read that hits the address being written
// in the same cycle is held off one cycle so it returns the new data.
module ebr_port_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ebr_port_arbiter_if.slave   bus
);

    typedef enum logic {
        SelA = 1'b0,
        SelB = 1'b1
    } sel_e;

    // Round-robin pointers: last requester granted under contention
    sel_e              r_wr_last;
    sel_e              r_rd_last;
    // Outstanding read response: owner tag and pending flag
    sel_e              r_rd_who;
    logic              r_rd_pend;

    logic              w_a_wr;
    logic              w_b_wr;
    logic              w_a_rd;
    logic              w_b_rd;
    logic              w_wr_both;
    logic              w_rd_both;
    sel_e              w_wr_sel;
    sel_e              w_rd_sel;
    logic              w_wr_gnt;
    logic              w_rd_req;
    logic              w_rd_gnt;
    logic              w_collide;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_wmask;
    logic [ADDR_W-1:0] w_raddr;

    // Classify requests; during reset nothing is a candidate, so every grant is forced off
    always_comb begin
        w_a_wr = rst_n & bus.a_valid &  bus.a_we;
        w_b_wr = rst_n & bus.b_valid &  bus.b_we;
        w_a_rd = rst_n & bus.a_valid & ~bus.a_we;
        w_b_rd = rst_n & bus.b_valid & ~bus.b_we;
    end

    // Write arbitration: sole candidate wins, otherwise the one not granted last time
    always_comb begin
        w_wr_both = w_a_wr & w_b_wr;
        w_wr_gnt  = w_a_wr | w_b_wr;
        if (w_wr_both) begin
            w_wr_sel = (r_wr_last == SelB) ? SelA : SelB;
        end else begin
            w_wr_sel = w_b_wr ? SelB : SelA;
        end
        w_waddr = (w_wr_sel == SelB) ? bus.b_addr  : bus.a_addr;
        w_wdata = (w_wr_sel == SelB) ? bus.b_wdata : bus.a_wdata;
        w_wmask = (w_wr_sel == SelB) ? bus.b_mask  : bus.a_mask;
    end

    // Read arbitration: same scheme with its own pointer
    always_comb begin
        w_rd_both = w_a_rd & w_b_rd;
        w_rd_req  = w_a_rd | w_b_rd;
        if (w_rd_both) begin
            w_rd_sel = (r_rd_last == SelB) ? SelA : SelB;
        end else begin
            w_rd_sel = w_b_rd ? SelB : SelA;
        end
        w_raddr = (w_rd_sel == SelB) ? bus.b_addr : bus.a_addr;
    end

    // Write wins a same-address collision; the read retries and then sees the new word
    always_comb begin
        w_collide = w_wr_gnt & w_rd_req & (w_waddr == w_raddr);
        w_rd_gnt  = w_rd_req & ~w_collide;
    end

    // Drive readies and RAM pins; idle sides present zeros
    always_comb begin
        bus.a_ready   = (w_wr_gnt & (w_wr_sel == SelA)) | (w_rd_gnt & (w_rd_sel == SelA));
        bus.b_ready   = (w_wr_gnt & (w_wr_sel == SelB)) | (w_rd_gnt & (w_rd_sel == SelB));

        bus.ram_we    = w_wr_gnt;
        bus.ram_waddr = w_wr_gnt ? w_waddr : '0;
        bus.ram_wdata = w_wr_gnt ? w_wdata : '0;
        bus.ram_mask  = w_wr_gnt ? w_wmask : '0;

        bus.ram_re    = w_rd_gnt;
        bus.ram_raddr = w_rd_gnt ? w_raddr : '0;
    end

    // Response steering: the EBR output register holds the word one cycle after the grant
    always_comb begin
        bus.a_rsp_valid = r_rd_pend & (r_rd_who == SelA);
        bus.b_rsp_valid = r_rd_pend & (r_rd_who == SelB);
        bus.rsp_rdata   = bus.ram_rdata;
    end

    // Pointers move only when a contended grant is actually issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_last <= SelB;
            r_rd_last <= SelB;
        end else begin
            if (w_wr_gnt && w_wr_both) begin
                r_wr_last <= w_wr_sel;
            end
            if (w_rd_gnt && w_rd_both) begin
                r_rd_last <= w_rd_sel;
            end
        end
    end

    // Track the read issued this cycle so its response is tagged next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_rd_who  <= SelA;
        end else begin
            r_rd_pend <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_who <= w_rd_sel;
            end
        end
    end

endmodule

// File: tb/tb_ebr_port_arbiter.sv
// Directed bench for ebr_port_arbiter with a behavioural mode-0 EBR behind it.
module tb_ebr_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ebr_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    ebr_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EBR model: masked write, registered read; mask bit 1 keeps the old bit
    logic [15:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        bus.ram_rdata = 16'h0000;
    end
    always @(posedge clk) begin
        if (bus.ram_we)
            mem[bus.ram_waddr] <= (mem[bus.ram_waddr] & bus.ram_mask) |
                                  (bus.ram_wdata & ~bus.ram_mask);
        if (bus.ram_re)
            bus.ram_rdata <= mem[bus.ram_raddr];
    end

    typedef struct {
        logic        av, awe;
        logic [7:0]  aad;
        logic [15:0] awd, amk;
        logic        bv, bwe;
        logic [7:0]  bad;
        logic [15:0] bwd, bmk;
        logic        ea, eb, ere, ewe;
        logic [7:0]  erad, ewad;
        logic        ears, ebrs;
        logic [15:0] erd;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.a_valid = v.av; bus.a_we = v.awe; bus.a_addr = v.aad;
        bus.a_wdata = v.awd; bus.a_mask = v.amk;
        bus.b_valid = v.bv; bus.b_we = v.bwe; bus.b_addr = v.bad;
        bus.b_wdata = v.bwd; bus.b_mask = v.bmk;
    endtask

    task automatic check(input string tag, input vec_t v);
        chk({tag, " a_ready"}, 32'(bus.a_ready), 32'(v.ea));
        chk({tag, " b_ready"}, 32'(bus.b_ready), 32'(v.eb));
        chk({tag, " ram_re"}, 32'(bus.ram_re), 32'(v.ere));
        chk({tag, " ram_we"}, 32'(bus.ram_we), 32'(v.ewe));
        chk({tag, " ram_raddr"}, 32'(bus.ram_raddr), 32'(v.erad));
        chk({tag, " ram_waddr"}, 32'(bus.ram_waddr), 32'(v.ewad));
        chk({tag, " a_rsp_valid"}, 32'(bus.a_rsp_valid), 32'(v.ears));
        chk({tag, " b_rsp_valid"}, 32'(bus.b_rsp_valid), 32'(v.ebrs));
        if (v.ears || v.ebrs)
            chk({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.erd));
    endtask

    // One cycle: drive after the rising edge, check mid-cycle, advance
    task automatic cycle(input string tag, input vec_t v);
        drive(v);
        @(negedge clk);
        check(tag, v);
        @(posedge clk);
        #1;
    endtask

    vec_t idle;
    vec_t h;

    initial begin
        n_vec = 0;
        n_err = 0;
        //            A: v we addr  wdata     mask      B: v we addr  wdata     mask
        //            exp: ea eb re we raddr  waddr  ars brs rdata
        vecs[0]  = '{0,0,8'h00,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     0,0,0,0,8'h00,8'h00,0,0,16'h0000};
        vecs[1]  = '{1,1,8'h10,16'hBEEF,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     1,0,0,1,8'h00,8'h10,0,0,16'h0000};
        vecs[2]  = '{1,0,8'h10,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     1,0,1,0,8'h10,8'h00,0,0,16'h0000};
        vecs[3]  = '{0,0,8'h00,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     0,0,0,0,8'h00,8'h00,1,0,16'hBEEF};
        // Write contention: A wins first
        vecs[4]  = '{1,1,8'h01,16'h1111,16'h0000, 1,1,8'h02,16'h2222,16'h0000,
                     1,0,0,1,8'h00,8'h01,0,0,16'h0000};
        vecs[5]  = '{0,0,8'h00,16'h0000,16'h0000, 1,1,8'h02,16'h2222,16'h0000,
                     0,1,0,1,8'h00,8'h02,0,0,16'h0000};
        // Continuous read contention: A, B, A, B, A, B
        vecs[6]  = '{1,0,8'h01,16'h0000,16'h0000, 1,0,8'h02,16'h0000,16'h0000,
                     1,0,1,0,8'h01,8'h00,0,0,16'h0000};
        vecs[7]  = '{1,0,8'h01,16'h0000,16'h0000, 1,0,8'h02,16'h0000,16'h0000,
                     0,1,1,0,8'h02,8'h00,1,0,16'h1111};
        vecs[8]  = '{1,0,8'h01,16'h0000,16'h0000, 1,0,8'h02,16'h0000,16'h0000,
                     1,0,1,0,8'h01,8'h00,0,1,16'h2222};
        vecs[9]  = '{1,0,8'h01,16'h0000,16'h0000, 1,0,8'h02,16'h0000,16'h0000,
                     0,1,1,0,8'h02,8'h00,1,0,16'h1111};
        vecs[10] = '{1,0,8'h01,16'h0000,16'h0000, 1,0,8'h02,16'h0000,16'h0000,
                     1,0,1,0,8'h01,8'h00,0,1,16'h2222};
        vecs[11] = '{1,0,8'h01,16'h0000,16'h0000, 1,0,8'h02,16'h0000,16'h0000,
                     0,1,1,0,8'h02,8'h00,1,0,16'h1111};
        vecs[12] = '{0,0,8'h00,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     0,0,0,0,8'h00,8'h00,0,1,16'h2222};
        // Masked write: upper byte kept -> 0x11FF
        vecs[13] = '{1,1,8'h01,16'hFFFF,16'hFF00, 0,0,8'h00,16'h0000,16'h0000,
                     1,0,0,1,8'h00,8'h01,0,0,16'h0000};
        vecs[14] = '{1,0,8'h01,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     1,0,1,0,8'h01,8'h00,0,0,16'h0000};
        vecs[15] = '{0,0,8'h00,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     0,0,0,0,8'h00,8'h00,1,0,16'h11FF};
        // Collision: B's read of 0x20 stalls one cycle, then sees 0x1234
        vecs[16] = '{1,1,8'h20,16'h1234,16'h0000, 1,0,8'h20,16'h0000,16'h0000,
                     1,0,0,1,8'h00,8'h20,0,0,16'h0000};
        vecs[17] = '{0,0,8'h00,16'h0000,16'h0000, 1,0,8'h20,16'h0000,16'h0000,
                     0,1,1,0,8'h20,8'h00,0,0,16'h0000};
        vecs[18] = '{0,0,8'h00,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     0,0,0,0,8'h00,8'h00,0,1,16'h1234};
        // Parallel issue: A reads 0x05 while B writes 0x06
        vecs[19] = '{1,0,8'h05,16'h0000,16'h0000, 1,1,8'h06,16'h5555,16'h0000,
                     1,1,1,1,8'h05,8'h06,0,0,16'h0000};
        vecs[20] = '{0,0,8'h00,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     0,0,0,0,8'h00,8'h00,1,0,16'h0000};
        // Colliding write stream stalls the read every cycle
        vecs[21] = '{1,1,8'h30,16'hAAAA,16'h0000, 1,0,8'h30,16'h0000,16'h0000,
                     1,0,0,1,8'h00,8'h30,0,0,16'h0000};
        vecs[22] = '{1,1,8'h30,16'hBBBB,16'h0000, 1,0,8'h30,16'h0000,16'h0000,
                     1,0,0,1,8'h00,8'h30,0,0,16'h0000};
        vecs[23] = '{0,0,8'h00,16'h0000,16'h0000, 1,0,8'h30,16'h0000,16'h0000,
                     0,1,1,0,8'h30,8'h00,0,0,16'h0000};
        vecs[24] = '{0,0,8'h00,16'h0000,16'h0000, 0,0,8'h00,16'h0000,16'h0000,
                     0,0,0,0,8'h00,8'h00,0,1,16'hBBBB};
        idle = vecs[0];

        // Reset for 3 cycles with live requests: everything must stay quiet
        rst_n = 1'b0;
        h = idle;
        h.av = 1'b1; h.aad = 8'h10; h.bv = 1'b1; h.bwe = 1'b1; h.bad = 8'h11;
        for (int i = 0; i < 3; i++) cycle($sformatf("rst%0d", i), h);
        rst_n = 1'b1;
        cycle("post_rst_idle", idle);

        for (int i = 0; i < NV; i++) cycle($sformatf("vec%0d", i), vecs[i]);

        // Move rd_last to A, then reset right after a pending A read
        h = vecs[6];
        cycle("pre_rst_contend", h);
        h = vecs[14];
        h.aad = 8'h10; h.erad = 8'h10; h.ears = 1'b1; h.erd = 16'h11FF;
        drive(h);
        @(negedge clk);
        check("pre_rst_read", h);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(idle);
        for (int i = 0; i < 2; i++) cycle($sformatf("mid_rst%0d", i), idle);
        rst_n = 1'b1;
        // Pointer back at B, so A wins the first read contention again
        h = vecs[6];
        cycle("post_rst_contend", h);
        h = idle;
        h.ears = 1'b1; h.erd = 16'h11FF;
        cycle("post_rst_rsp", h);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ebr_port_arbiter.md
# ebr_port_arbiter

Shares one 256 x 16 iCE40 embedded block RAM (EBR, mode 0: 16-bit write and read) between two requesters, A and B. The RAM has one read port and one write port. The arbiter grants reads and writes independently each cycle, so one read and one write can issue together. It applies round-robin fairness per port and resolves same-address read/write collisions so that readers always observe the newest data. It sits between the pulse-processing clients and the EBR primitive, and drives the RAM's RADDR/RE/WADDR/WE/WDATA/MASK with RCLKE=WCLKE=1 tied outside.

## Interface
- ADDR_W, 8, address width; the RAM is 256 deep in mode 0.
- DATA_W, 16, data and mask width.
- clk  in  1  single clock; drives the arbiter and both RAM clocks.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid / b_valid  in  1  request present; held stable until accepted.
- a_ready / b_ready  out  1  request accepted this cycle (combinational grant).
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  ADDR_W  word address.
- a_wdata / b_wdata  in  DATA_W  write data.
- a_mask / b_mask  in  DATA_W  per-bit write mask; 1 = bit not written.
- a_rsp_valid / b_rsp_valid  out  1  read data valid for that requester.
- rsp_rdata  out  DATA_W  read data, shared; qualified by the rsp_valid signals.
- ram_re, ram_raddr  out  1, ADDR_W  RAM read enable and read address.
- ram_we, ram_waddr, ram_wdata, ram_mask  out  1, ADDR_W, DATA_W, DATA_W  RAM write side.
- ram_rdata  in  DATA_W  registered RAM output.

## Operation
- Classification each cycle: a valid request with we=1 is a write candidate; we=0 is a read candidate.
- Write arbitration:
  - One write candidate: it is granted.
  - Two write candidates: grant goes to the requester not named by wr_last. wr_last then updates to the granted requester.
  - wr_last resets to B, so A wins the first contention.
- Read arbitration: identical scheme with its own pointer rd_last, which resets to B.
- Collision rule: if the granted write and the selected read have equal addresses in the same cycle, the read is not granted. Its ready stays 0, rd_last does not update, and the read retries next cycle, where it observes the written data.
- Outputs driven by the grants:
  - x_ready = 1 iff x holds a read grant or a write grant.
  - ram_we = 1 with the write winner's addr/wdata/mask.
  - ram_re = 1 with the read winner's addr.
  - When a side is idle, its RAM address/data/mask outputs are 0.
- Response: a 1-bit registered tag rd_who plus rd_pend.
  - x_rsp_valid = rd_pend && rd_who == x.
  - rsp_rdata = ram_rdata, passed through.
  - Responses have no backpressure; the requester must accept them.
- A requester may issue a new request on every cycle it is granted. Back-to-back reads produce back-to-back responses.
- Reset (asynchronous, any time):
  - rd_pend = 0, wr_last = B, rd_last = B.
  - While rst_n = 0, all readies, ram_re and ram_we are forced to 0.
  - An in-flight read response is discarded. Writes not yet clocked are not performed.
- Reset values of outputs: all readies 0, a_rsp_valid 0, b_rsp_valid 0, ram_re 0, ram_we 0, all addr/data/mask outputs 0. rsp_rdata follows ram_rdata.

## Timing
- Grant/ready: combinational from valid/we/addr and the registered pointers, in the same cycle as the request.
- Write: committed to RAM at the clk edge ending the grant cycle.
- Read latency: grant in cycle n, RAM samples at the edge ending n, x_rsp_valid is high for exactly cycle n+1.
- Collision stall: exactly 1 cycle when the write stream does not keep colliding. A colliding write stream to the same address stalls the read each cycle. The write path always has priority on collision.
- Fairness: under continuous contention on one port, grants alternate A, B, A, B…, so the maximum wait is 1 cycle.
- Pointer and rd_pend updates occur on clk rising edge only.

## Test plan
- Reset then idle: rst_n low for 3 cycles → all readies, ram_re, ram_we and rsp_valids are 0. After release with no valid, nothing changes.
- A writes 0xBEEF to 0x10 with mask 0x0000, then A reads 0x10 → a_ready in both request cycles; a_rsp_valid one cycle after the read grant with rsp_rdata = 0xBEEF; b_rsp_valid stays 0.
- A and B read continuously (A addr 0x01, B addr 0x02), for 6 cycles → grants A, B, A, B, A, B. rsp_valid alternates one cycle later with the correct data.
- Same cycle: A writes 0x1234 to 0x20 while B reads 0x20 (old value 0x0000) → a_ready=1, b_ready=0. Next cycle b_ready=1, and b_rsp_valid returns 0x1234.
- Parallel issue: A reads 0x05 while B writes 0x06 → both readies 1 in the same cycle; ram_re and ram_we are both 1.
- Reset asserted the cycle after A's read grant → a_rsp_valid stays 0 and the pointers return to reset values. After release, the first A/B read contention grants A.
